imem_loader: RTL and testbench

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader_pkg.sv | 19 +
 rtl/imem_loader_word_assembler.sv | 41 ++++
 rtl/imem_loader.sv | 117 +++++++++++
 tb/tb_imem_loader.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM state encodings,
// default memory depth and frame-layout constants.
package imem_loader_pkg;

  localparam int DEPTH_DEFAULT = 1024;
  localparam int HDR_BYTES     = 2;
  localparam int CSUM_BYTES    = 1;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE = 3'd0;
  localparam state_t ST_HDR0 = 3'd1;
  localparam state_t ST_HDR1 = 3'd2;
  localparam state_t ST_DATA = 3'd3;
  localparam state_t ST_CSUM = 3'd4;
  localparam state_t ST_DONE = 3'd5;
  localparam state_t ST_ERR  = 3'd6;

endpackage

// File: rtl/imem_loader_word_assembler.sv
// Packs an LSB-first byte stream into 32-bit words; word_valid pulses for
// one cycle after the fourth byte of each word is taken.
module word_assembler (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic [1:0]  byte_cnt,
  output logic        word_valid,
  output logic [31:0] word_data
);

  logic [23:0] shreg;

  always_ff @(posedge clk) begin
    if (!rst) begin
      shreg      <= '0;
      byte_cnt   <= '0;
      word_valid <= 1'b0;
      word_data  <= '0;
    end else if (clear) begin
      shreg      <= '0;
      byte_cnt   <= '0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= 1'b0;
      if (byte_valid) begin
        byte_cnt <= byte_cnt + 2'd1;
        // New bytes enter at the top so the first byte ends up in [7:0].
        if (byte_cnt == 2'd3) begin
          word_data  <= {byte_data, shreg};
          word_valid <= 1'b1;
        end else begin
          shreg <= {byte_data, shreg[23:8]};
        end
      end
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Receives a length-prefixed, XOR-checksummed byte frame, writes it into
// instruction memory word by word and releases the processor reset on success.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT,
  parameter int AW    = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          in_valid,
  input  logic [7:0]    in_data,
  output logic          in_ready,
  output logic          we,
  output logic [AW-1:0] waddr,
  output logic [31:0]   wdata,
  output logic          cpu_rst_n,
  output logic          done,
  output logic          error,
  output logic [2:0]    state_dbg
);

  // Stream handshake: a byte moves only on a cycle where in_valid && in_ready;
  // in_ready depends on state alone, so a held byte is never dropped.
  localparam logic [16:0] DEPTH_L = 17'(DEPTH);

  state_t      state;
  logic [7:0]  n_lo;
  logic [15:0] words_left;
  logic [7:0]  csum;
  logic        accept;
  logic        data_accept;
  logic        load_start;
  logic [1:0]  byte_cnt;
  logic [15:0] n_full;

  assign in_ready    = (state == ST_HDR0) || (state == ST_HDR1) ||
                       (state == ST_DATA) || (state == ST_CSUM);
  assign accept      = in_valid && in_ready;
  assign data_accept = accept && (state == ST_DATA);
  assign load_start  = start && ((state == ST_IDLE) || (state == ST_DONE) ||
                                 (state == ST_ERR));
  assign n_full      = {in_data, n_lo};
  assign state_dbg   = state;

  word_assembler u_asm (
    .clk        (clk),
    .rst        (rst),
    .clear      (load_start),
    .byte_valid (data_accept),
    .byte_data  (in_data),
    .byte_cnt   (byte_cnt),
    .word_valid (we),
    .word_data  (wdata)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= ST_IDLE;
      n_lo       <= '0;
      words_left <= '0;
      csum       <= '0;
      waddr      <= '0;
      cpu_rst_n  <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      // Hold the index on the final slot so N == DEPTH never wraps it.
      if (we && (32'(waddr) != DEPTH - 1)) waddr <= waddr + 1'b1;

      case (state)
        ST_HDR0: if (accept) begin
          n_lo  <= in_data;
          state <= ST_HDR1;
        end
        ST_HDR1: if (accept) begin
          words_left <= n_full;
          if (n_full == 16'd0)              state <= ST_CSUM;
          else if ({1'b0, n_full} > DEPTH_L) begin
            state <= ST_ERR;
            error <= 1'b1;
          end else                          state <= ST_DATA;
        end
        ST_DATA: if (accept) begin
          csum <= csum ^ in_data;
          if (byte_cnt == 2'd3) begin
            words_left <= words_left - 16'd1;
            if (words_left == 16'd1) state <= ST_CSUM;
          end
        end
        ST_CSUM: if (accept) begin
          if (in_data == csum) begin
            state <= ST_DONE;
            done  <= 1'b1;
          end else begin
            state <= ST_ERR;
            error <= 1'b1;
          end
        end
        ST_DONE: cpu_rst_n <= 1'b1;
        default: ;
      endcase

      if (load_start) begin
        state      <= ST_HDR0;
        csum       <= '0;
        waddr      <= '0;
        words_left <= '0;
        cpu_rst_n  <= 1'b0;
        done       <= 1'b0;
        error      <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: frame loads, checksum failure, empty and
// oversize frames, mid-load reset and stalled-stream loads.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready;
  logic        we;
  logic [9:0]  waddr;
  logic [31:0] wdata;
  logic        cpu_rst_n;
  logic        done;
  logic        error;
  logic [2:0]  state_dbg;

  int checks = 0;
  int failures = 0;

  logic [7:0]  frame [11];
  logic [9:0]  got_addr [$];
  logic [31:0] got_data [$];

  imem_loader #(.DEPTH(1024), .AW(10)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .we        (we),
    .waddr     (waddr),
    .wdata     (wdata),
    .cpu_rst_n (cpu_rst_n),
    .done      (done),
    .error     (error),
    .state_dbg (state_dbg)
  );

  always #5 clk = ~clk;

  // Write monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (we) begin
      got_addr.push_back(waddr);
      got_data.push_back(wdata);
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0; in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    repeat (gap) begin
      @(posedge clk); #1;
    end
    in_valid = 1'b1;
    in_data  = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = 8'h00;
  endtask

  task automatic set_frame(input logic [7:0] last);
    frame[0] = 8'h02; frame[1] = 8'h00;
    frame[2] = 8'h13; frame[3] = 8'h04; frame[4] = 8'h00; frame[5] = 8'h00;
    frame[6] = 8'h93; frame[7] = 8'h04; frame[8] = 8'h00; frame[9] = 8'h05;
    frame[10] = last;
  endtask

  task automatic check_two_writes(input string tag);
    checks++;
    if (got_addr.size() !== 2) begin
      failures++;
      $display("FAIL %s_write_count got=%0d exp=2", tag, got_addr.size());
    end else begin
      checks++;
      if (got_addr[0] !== 10'd0 || got_data[0] !== 32'h0000_0413) begin
        failures++;
        $display("FAIL %s_word0 got=[%0d]=%h exp=[0]=00000413", tag, got_addr[0], got_data[0]);
      end
      checks++;
      if (got_addr[1] !== 10'd1 || got_data[1] !== 32'h0500_0493) begin
        failures++;
        $display("FAIL %s_word1 got=[%0d]=%h exp=[1]=05000493", tag, got_addr[1], got_data[1]);
      end
    end
  endtask

  task automatic check_done_release(input string tag);
    checks++;
    if (done !== 1'b1 || error !== 1'b0 || cpu_rst_n !== 1'b0) begin
      failures++;
      $display("FAIL %s_done got=done%b err%b cpu%b exp=done1 err0 cpu0", tag, done, error, cpu_rst_n);
    end
    @(posedge clk); #1;
    checks++;
    if (cpu_rst_n !== 1'b1 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL %s_cpu_release got=cpu%b rdy%b exp=cpu1 rdy0", tag, cpu_rst_n, in_ready);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({in_ready, we, waddr, wdata, cpu_rst_n, done, error} !== '0 || state_dbg !== 3'd0) begin
      failures++;
      $display("FAIL reset_outputs got=rdy%b we%b a%0d d%h cpu%b done%b err%b st%0d exp=all0",
               in_ready, we, waddr, wdata, cpu_rst_n, done, error, state_dbg);
    end
  endtask

  task automatic test_load();
    set_frame(8'h85);
    got_addr.delete(); got_data.delete();
    pulse_start();
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL load_ready_hdr0 got=%b exp=1", in_ready);
    end
    for (int i = 0; i < 11; i++) send_byte(frame[i], 0);
    check_done_release("load");
    repeat (2) @(posedge clk); #1;
    check_two_writes("load");
  endtask

  task automatic test_bad_csum();
    set_frame(8'h84);
    got_addr.delete(); got_data.delete();
    pulse_start();
    for (int i = 0; i < 11; i++) send_byte(frame[i], 0);
    repeat (3) @(posedge clk); #1;
    checks++;
    if (error !== 1'b1 || done !== 1'b0 || cpu_rst_n !== 1'b0) begin
      failures++;
      $display("FAIL badcsum_flags got=err%b done%b cpu%b exp=err1 done0 cpu0", error, done, cpu_rst_n);
    end
    check_two_writes("badcsum");
  endtask

  task automatic test_n_zero();
    got_addr.delete(); got_data.delete();
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    check_done_release("nzero");
    checks++;
    if (got_addr.size() !== 0) begin
      failures++;
      $display("FAIL nzero_no_write got=%0d exp=0", got_addr.size());
    end
  endtask

  task automatic test_oversize();
    got_addr.delete(); got_data.delete();
    pulse_start();
    send_byte(8'h01, 0);
    send_byte(8'h04, 0);
    checks++;
    if (error !== 1'b1 || done !== 1'b0 || in_ready !== 1'b0 || state_dbg !== 3'd6) begin
      failures++;
      $display("FAIL oversize_err got=err%b done%b rdy%b st%0d exp=err1 done0 rdy0 st6",
               error, done, in_ready, state_dbg);
    end
    send_byte(8'h11, 2);
    checks++;
    if (got_addr.size() !== 0 || cpu_rst_n !== 1'b0) begin
      failures++;
      $display("FAIL oversize_no_write got=%0d cpu%b exp=0 cpu0", got_addr.size(), cpu_rst_n);
    end
  endtask

  task automatic test_reset_mid();
    set_frame(8'h85);
    got_addr.delete(); got_data.delete();
    pulse_start();
    for (int i = 0; i < 6; i++) send_byte(frame[i], 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    checks++;
    if ({in_ready, we, waddr, wdata, cpu_rst_n, done, error} !== '0 || state_dbg !== 3'd0) begin
      failures++;
      $display("FAIL midrst_outputs got=rdy%b we%b a%0d d%h cpu%b done%b err%b st%0d exp=all0",
               in_ready, we, waddr, wdata, cpu_rst_n, done, error, state_dbg);
    end
    checks++;
    if (got_addr.size() !== 1) begin
      failures++;
      $display("FAIL midrst_write_count got=%0d exp=1", got_addr.size());
    end else begin
      checks++;
      if (got_addr[0] !== 10'd0 || got_data[0] !== 32'h0000_0413) begin
        failures++;
        $display("FAIL midrst_word0 got=[%0d]=%h exp=[0]=00000413", got_addr[0], got_data[0]);
      end
    end
    test_load();
  endtask

  task automatic test_gaps();
    set_frame(8'h85);
    got_addr.delete(); got_data.delete();
    // Byte offered together with start in IDLE must not be consumed.
    in_valid = 1'b1;
    in_data  = 8'hAA;
    pulse_start();
    in_valid = 1'b0;
    checks++;
    if (state_dbg !== 3'd1) begin
      failures++;
      $display("FAIL gaps_start_with_byte got=st%0d exp=st1", state_dbg);
    end
    for (int i = 0; i < 11; i++) begin
      send_byte(frame[i], int'($urandom_range(0, 5)));
      if (i == 4) pulse_start();
    end
    check_done_release("gaps");
    repeat (2) @(posedge clk); #1;
    check_two_writes("gaps");
  endtask

  initial begin
    test_reset();
    test_load();
    test_bad_csum();
    test_n_zero();
    test_oversize();
    test_reset_mid();
    test_gaps();
    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
